serial_adder_ctrl: RTL



---
 rtl/serial_adder_ctrl_pkg.sv | 5 +
 rtl/serial_adder_ctrl_if.sv | 32 +++
 rtl/serial_adder_ctrl_fa_bit.sv | 11 +
 rtl/serial_adder_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/operand/result bundle; ovf present only with SERIAL_ADDER_CTRL_OVF_EN
interface serial_adder_ctrl_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  logic             ovf;
`endif
  modport master (
    output start, a, b, ci,
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    input ovf,
`endif
    input busy, done, sum, co
  );
  modport slave (
    input start, a, b, ci,
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    output ovf,
`endif
    output busy, done, sum, co
  );
endinterface

// File: rtl/serial_adder_ctrl_fa_bit.sv
// fa_bit: combinational one-bit full adder
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller, one bit per clock; SERIAL_ADDER_CTRL_OVF_EN adds ovf
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;
  logic             r_busy;
  logic             r_done;
  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_next;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  logic             r_ovf;
  assign bus.ovf = r_ovf;
`endif

  fa_bit u_fa (
    .a (r_a[0]),
    .b (r_b[0]),
    .ci(r_c),
    .s (w_s),
    .co(w_co)
  );

  assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.sum    = r_sum;
  assign bus.co     = r_co;

  // Controller: load on accepted start, shift one bit pair per edge, publish result on the last bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_sum_sr <= '0;
      r_sum    <= '0;
      r_co     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_c      <= bus.ci;
            r_cnt    <= '0;
            r_sum_sr <= '0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end else begin
            r_state  <= IDLE;
          end
        end
        SHIFT: begin
          r_c      <= w_co;
          r_sum_sr <= w_sum_next;
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            r_sum   <= w_sum_next;
            r_co    <= w_co;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
            r_ovf   <= r_c ^ w_co;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
